// File: rtl/digit_serial_addsub_pkg.sv
// digit_serial_addsub_pkg
// Definitions shared by the digit-serial adder/subtractor and its cell:
//   - state_e    : word-tracking FSM states (IDLE, RUN)
//   - MODE_ADD/MODE_SUB : values of the mode input
//   - signed_ovf : two's-complement overflow from the two MSB carries
package digit_serial_addsub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN
   } state_e;

   // Overflow occurs when the carry into the sign bit differs from the
   // carry out of it.
   function automatic logic signed_ovf(input logic carry_msb, input logic carry_out);
      return carry_msb ^ carry_out;
   endfunction

endpackage

// File: rtl/digit_serial_addsub_cell.sv
// digit_addsub_cell
// Combinational DIGIT_W-bit adder slice with optional B inversion.
// Ports:
//   a, b       : operand digits
//   sub        : MODE_SUB inverts b (the +1 comes in through carry_in)
//   carry_in   : carry into bit 0
//   sum        : result digit
//   carry_out  : carry out of the MSB
//   carry_msb  : carry into the MSB (for overflow detection)
module digit_addsub_cell
   import digit_serial_addsub_pkg::*;
#(
   parameter int DIGIT_W = 1
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               sub,
   input  logic               carry_in,
   output logic [DIGIT_W-1:0] sum,
   output logic               carry_out,
   output logic               carry_msb
);

   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W:0]   full;

   // Subtraction is A + ~B + 1; the +1 is the seeded carry of the first digit.
   // The carry into the MSB is recovered from the MSB sum bit and its operands,
   // which works for any digit width including 1.
   always_comb begin
      b_eff     = (sub == MODE_SUB) ? ~b : b;
      full      = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, carry_in};
      sum       = full[DIGIT_W-1:0];
      carry_out = full[DIGIT_W];
      carry_msb = full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
   end

endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
// Digit-serial two's-complement adder/subtractor. Operands arrive LS digit
// first, DIGIT_W bits per beat, WORD_DIGITS beats per word. Each accepted
// beat produces one registered result digit one cycle later.
// Ports:
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid, in_first  : beat present / beat is LS digit of a new word
//   mode                : 0 add, 1 subtract (taken on the first beat only)
//   a_digit, b_digit    : operand digits
//   sum_digit, out_valid, out_last : registered result digit and framing
//   carry_out, overflow : word-level flags, updated with out_last
//   proto_err           : one-cycle pulse on a framing violation
//   busy                : a word is in progress
module digit_serial_addsub
   import digit_serial_addsub_pkg::*;
#(
   parameter int DIGIT_W     = 1,
   parameter int WORD_DIGITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_first,
   input  logic               mode,
   input  logic [DIGIT_W-1:0] a_digit,
   input  logic [DIGIT_W-1:0] b_digit,
   output logic [DIGIT_W-1:0] sum_digit,
   output logic               out_valid,
   output logic               out_last,
   output logic               carry_out,
   output logic               overflow,
   output logic               proto_err,
   output logic               busy
);

   localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic               mode_q;

   logic               take_first;
   logic               take_cont;
   logic               take_beat;
   logic               is_last;
   logic               mode_eff;
   logic               carry_in;
   logic               perr_next;
   logic [DIGIT_W-1:0] cell_sum;
   logic               cell_cout;
   logic               cell_cmsb;

   // Beat qualification. A first beat is always taken and restarts the word,
   // even mid-word; a continuation beat only counts while a word is running.
   // The first beat uses the live mode and seeds the carry with it, so a
   // subtraction gets its +1 without an extra cycle. A first beat is never
   // the last because words have at least two digits.
   always_comb begin
      take_first = in_valid & in_first;
      take_cont  = in_valid & ~in_first & (state_q == RUN);
      take_beat  = take_first | take_cont;
      is_last    = take_cont & (cnt_q == LAST_IDX);
      mode_eff   = take_first ? mode : mode_q;
      carry_in   = take_first ? mode : carry_q;
      perr_next  = (take_first & (state_q == RUN)) |
                   (in_valid & ~in_first & (state_q == IDLE));
   end

   digit_addsub_cell #(
      .DIGIT_W (DIGIT_W)
   ) u_cell (
      .a         (a_digit),
      .b         (b_digit),
      .sub       (mode_eff),
      .carry_in  (carry_in),
      .sum       (cell_sum),
      .carry_out (cell_cout),
      .carry_msb (cell_cmsb)
   );

   // Word tracking: state, digit index, running carry and latched mode.
   // All of it holds while in_valid is low, so gaps do not disturb a word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         mode_q  <= MODE_ADD;
      end else begin
         if (take_first) begin
            state_q <= RUN;
            cnt_q   <= CNT_W'(1);
            mode_q  <= mode;
         end else if (take_cont) begin
            if (is_last) begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end else begin
               cnt_q   <= cnt_q + CNT_W'(1);
            end
         end
         if (take_beat) begin
            carry_q <= cell_cout;
         end
      end
   end

   // Output register stage: one cycle of latency per beat. The word flags
   // are only refreshed on the final digit and otherwise keep the result of
   // the previous word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_digit <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         out_valid <= take_beat;
         out_last  <= is_last;
         proto_err <= perr_next;
         if (take_beat) begin
            sum_digit <= cell_sum;
         end
         if (is_last) begin
            carry_out <= cell_cout;
            overflow  <= signed_ovf(cell_cmsb, cell_cout);
         end
      end
   end

   assign busy = (state_q == RUN);

endmodule
